// File: rtl/opl3_pkg.sv
// Shared OPL3 types and constants: register-write transaction, host port sizing, status bit map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package opl3_pkg;

    localparam int REG_FILE_DATA_WIDTH = 8;
    localparam int REG_FILE_ADDR_WIDTH = 8;

    localparam int HOST_FIFO_DEPTH = 16;
    localparam int HOST_MIN_WR_GAP = 32;

    localparam int STATUS_IRQ_BIT  = 7;
    localparam int STATUS_FT1_BIT  = 6;
    localparam int STATUS_FT2_BIT  = 5;
    localparam int STATUS_OVF_BIT  = 4;
    localparam int STATUS_BUSY_BIT = 3;

    typedef struct packed {
        logic                           valid;
        logic                           bank_num;
        logic [REG_FILE_ADDR_WIDTH-1:0] address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl3_reg_wr_t;

    // Queued entries carry everything but valid, which only exists on the output register.
    localparam int HOST_FIFO_WIDTH = $bits(opl3_reg_wr_t) - 1;

endpackage

// File: rtl/opl3_sync_fifo.sv
// Generic synchronous FIFO, power-of-2 depth, show-ahead read data.
// Latency: pushed word visible on pop_dat the edge after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module opl3_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != DEPTH_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/opl3_host_port.sv
// OPL3 four-port host interface: address/data ports per bank, paced register writes, status read.
// Latency: data write at edge N -> opl3_reg_wr.valid after edge N+1; bus_dout one edge after bus_rd.
// Backpressure: none toward the host; data writes into a full FIFO are dropped and set overflow.
module opl3_host_port
    import opl3_pkg::*;
#(
    parameter int FIFO_DEPTH = HOST_FIFO_DEPTH,
    parameter int MIN_WR_GAP = HOST_MIN_WR_GAP
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           bus_wr,
    input  logic                           bus_rd,
    input  logic [1:0]                     bus_addr,
    input  logic [REG_FILE_DATA_WIDTH-1:0] bus_din,
    output logic [REG_FILE_DATA_WIDTH-1:0] bus_dout,
    input  logic                           irq_in,
    input  logic                           ft1_in,
    input  logic                           ft2_in,
    output opl3_reg_wr_t                   opl3_reg_wr,
    output logic                           overflow,
    output logic                           busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = (MIN_WR_GAP > 1) ? $clog2(MIN_WR_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_WR_GAP - 1);

    logic [REG_FILE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                           bank_q, bank_d;
    logic [GAP_W-1:0]               gap_q, gap_d;
    opl3_reg_wr_t                   out_q, out_d;
    logic [REG_FILE_DATA_WIDTH-1:0] dout_q, dout_d;
    logic [REG_FILE_DATA_WIDTH-1:0] status;
    logic                           overflow_q, overflow_d;

    logic                           addr_wr, data_wr, status_rd;
    logic                           fifo_push, fifo_pop, drop;
    logic                           fifo_full, fifo_empty;
    logic [CNT_W-1:0]               fifo_count;
    logic [HOST_FIFO_WIDTH-1:0]     fifo_din, fifo_dout;

    always_comb begin
        addr_wr   = bus_wr && !bus_addr[0];
        data_wr   = bus_wr && bus_addr[0];
        status_rd = bus_rd && (bus_addr == 2'b00);
        fifo_pop  = !fifo_empty && (gap_q == '0);
        fifo_push = data_wr && (!fifo_full || fifo_pop);
        drop      = data_wr && !fifo_push;
        // The bank always comes from the address latch; bus_addr[1] on a data write is ignored.
        fifo_din  = {bank_q, addr_q, bus_din};
    end

    opl3_sync_fifo #(
        .WIDTH (HOST_FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (fifo_din),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign busy = (fifo_count != '0) || out_q.valid;

    always_comb begin
        status                  = '0;
        status[STATUS_IRQ_BIT]  = irq_in;
        status[STATUS_FT1_BIT]  = ft1_in;
        status[STATUS_FT2_BIT]  = ft2_in;
        status[STATUS_OVF_BIT]  = overflow_q;
        status[STATUS_BUSY_BIT] = busy;
    end

    always_comb begin
        addr_d     = addr_q;
        bank_d     = bank_q;
        gap_d      = gap_q;
        out_d      = '0;
        dout_d     = dout_q;
        overflow_d = overflow_q;

        if (addr_wr) begin
            addr_d = REG_FILE_ADDR_WIDTH'(bus_din);
            bank_d = bus_addr[1];
        end

        if (fifo_pop) begin
            out_d = {1'b1, fifo_dout};
            gap_d = GAP_RELOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        if (bus_rd) dout_d = status_rd ? status : '0;

        // A drop in the same cycle as a status read keeps the flag set.
        if (drop)           overflow_d = 1'b1;
        else if (status_rd) overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q     <= '0;
            bank_q     <= 1'b0;
            gap_q      <= '0;
            out_q      <= '0;
            dout_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            gap_q      <= gap_d;
            out_q      <= out_d;
            dout_q     <= dout_d;
            overflow_q <= overflow_d;
        end
    end

    assign opl3_reg_wr = out_q;
    assign bus_dout    = dout_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_opl3_host_port.sv
// Bench for opl3_host_port: queue/timestamp reference model, per-cycle compare, directed scenarios, random traffic.
module tb_opl3_host_port;
    import opl3_pkg::*;

    localparam int DEPTH = HOST_FIFO_DEPTH;
    localparam int GAP   = HOST_MIN_WR_GAP;

    logic         clk = 1'b0;
    logic         reset_n, bus_wr, bus_rd;
    logic [1:0]   bus_addr;
    logic [7:0]   bus_din, bus_dout;
    logic         irq_in, ft1_in, ft2_in;
    opl3_reg_wr_t opl3_reg_wr;
    logic         overflow, busy;

    always #5 clk = ~clk;

    opl3_host_port #(
        .FIFO_DEPTH (DEPTH),
        .MIN_WR_GAP (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .bus_addr    (bus_addr),
        .bus_din     (bus_din),
        .bus_dout    (bus_dout),
        .irq_in      (irq_in),
        .ft1_in      (ft1_in),
        .ft2_in      (ft2_in),
        .opl3_reg_wr (opl3_reg_wr),
        .overflow    (overflow),
        .busy        (busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic opl3_reg_wr_t mk(input logic b, input logic [7:0] a, input logic [7:0] d);
        opl3_reg_wr_t t;
        t.valid    = 1'b1;
        t.bank_num = b;
        t.address  = a;
        t.data     = d;
        return t;
    endfunction

    // Reference model: a queue of pending writes plus the earliest edge at which the next issue may happen.
    opl3_reg_wr_t mq[$];
    opl3_reg_wr_t m_out;
    logic [7:0]   m_dout, m_lat_addr;
    logic         m_lat_bank, m_ovf, m_busy;
    int           next_issue = 0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin : model
        int           sz;
        bit           pop, drop, busy_pre, ovf_pre;
        opl3_reg_wr_t e;
        cyc++;
        if (!reset_n) begin
            mq.delete();
            m_out      = '0;
            m_dout     = '0;
            m_ovf      = 1'b0;
            m_lat_addr = '0;
            m_lat_bank = 1'b0;
            next_issue = 0;
            chk_en     = 1'b1;
        end else begin
            sz       = mq.size();
            busy_pre = (sz != 0) || m_out.valid;
            ovf_pre  = m_ovf;
            pop      = (sz > 0) && (cyc >= next_issue);
            m_out    = '0;
            if (pop) begin
                m_out      = mq.pop_front();
                next_issue = cyc + GAP;
            end
            drop = 1'b0;
            if (bus_wr && !bus_addr[0]) begin
                m_lat_addr = bus_din;
                m_lat_bank = bus_addr[1];
            end
            if (bus_wr && bus_addr[0]) begin
                if (sz < DEPTH || pop) begin
                    e = mk(m_lat_bank, m_lat_addr, bus_din);
                    mq.push_back(e);
                end else begin
                    drop = 1'b1;
                end
            end
            if (bus_rd)
                m_dout = (bus_addr == 2'b00) ? {irq_in, ft1_in, ft2_in, ovf_pre, busy_pre, 3'b000} : 8'h00;
            if (drop) m_ovf = 1'b1;
            else if (bus_rd && bus_addr == 2'b00) m_ovf = 1'b0;
        end
        m_busy = (mq.size() != 0) || m_out.valid;
    end

    opl3_reg_wr_t seen[$];
    int           seen_cyc[$];

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("reg_wr",   32'(opl3_reg_wr), 32'(m_out));
            chk("bus_dout", 32'(bus_dout),    32'(m_dout));
            chk("overflow", 32'(overflow),    32'(m_ovf));
            chk("busy",     32'(busy),        32'(m_busy));
        end
        if (opl3_reg_wr.valid === 1'b1) begin
            seen.push_back(opl3_reg_wr);
            seen_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus_wr   = 1'b1;
        bus_addr = a;
        bus_din  = d;
        step();
        bus_wr   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        bus_rd   = 1'b1;
        bus_addr = a;
        step();
        bus_rd   = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int n = 0;
        while (seen.size() < target && n < budget) begin
            step();
            n++;
        end
        if (seen.size() < target) timeout_fail(name);
    endtask

    task automatic wait_idle(input int budget, input string name, output int at);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        if (busy !== 1'b0) timeout_fail(name);
        at = cyc;
    endtask

    initial begin : stim
        int         base, base2, c0, p0, t_end;
        logic [7:0] d[5];
        int         wprob;

        reset_n = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = '0; bus_din = '0;
        irq_in = 1'b0; ft1_in = 1'b0; ft2_in = 1'b0;
        idle(3);
        chk("rst_reg_wr",   32'(opl3_reg_wr), 0);
        chk("rst_dout",     32'(bus_dout),    0);
        chk("rst_overflow", 32'(overflow),    0);
        chk("rst_busy",     32'(busy),        0);
        reset_n = 1'b1;
        idle(2);

        // Single write: bank 1, address 0xB0, data 0x2A; two-edge latency.
        bus_write(2'b10, 8'hB0);
        base = seen.size();
        c0   = cyc + 2;
        bus_write(2'b11, 8'h2A);
        wait_pulses(base + 1, 100, "t1_wait");
        chk("t1_count", seen.size() - base, 1);
        if (seen.size() > base) begin
            chk("t1_txn",     32'(seen[base]),   32'(mk(1'b1, 8'hB0, 8'h2A)));
            chk("t1_latency", seen_cyc[base],    c0);
        end

        // Pacing: five consecutive data writes come out 32 cycles apart.
        idle(40);
        bus_write(2'b00, 8'h20);
        base = seen.size();
        for (int i = 0; i < 5; i++) begin
            d[i] = 8'($urandom);
            bus_write(2'b01, d[i]);
        end
        wait_idle(400, "t2_idle", t_end);
        chk("t2_count", seen.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < seen.size()) begin
                chk("t2_txn", 32'(seen[base + i]), 32'(mk(1'b0, 8'h20, d[i])));
                if (i > 0) chk("t2_spacing", seen_cyc[base + i] - seen_cyc[base + i - 1], 32);
            end
        end
        if (seen.size() >= base + 5) chk("t2_busy_fall", t_end, seen_cyc[base + 4] + 1);

        // Overflow: one issued, then 17 back-to-back; the 17th is dropped.
        idle(40);
        base = seen.size();
        bus_write(2'b01, 8'h11);
        wait_pulses(base + 1, 100, "t3_first");
        for (int i = 0; i < 17; i++) bus_write(2'b01, 8'(8'h40 + i));
        chk("t3_ovf_set", 32'(overflow), 1);
        bus_read(2'b00);
        chk("t3_status_ovf",  32'(bus_dout[4]), 1);
        chk("t3_status_busy", 32'(bus_dout[3]), 1);
        chk("t3_ovf_clear",   32'(overflow),    0);
        wait_idle(17 * GAP + 200, "t3_idle", t_end);
        chk("t3_pulses", seen.size() - base, 17);

        // Full FIFO with a write landing on the pop edge.
        idle(40);
        base = seen.size();
        bus_write(2'b01, 8'h90);
        wait_pulses(base + 1, 100, "t4_first");
        p0 = (seen.size() > base) ? seen_cyc[base] : cyc;
        for (int i = 0; i < 16; i++) bus_write(2'b01, 8'(8'hA0 + i));
        for (int n = 0; n < 100 && cyc < p0 + GAP - 1; n++) step();
        bus_write(2'b01, 8'hEE);
        chk("t4_no_ovf", 32'(overflow), 0);
        wait_idle(18 * GAP + 200, "t4_idle", t_end);
        chk("t4_pulses", seen.size() - base, 18);
        if (seen.size() > 0) chk("t4_last", 32'(seen[seen.size() - 1].data), 32'h00EE);

        // Status read with timer flags; other ports read zero.
        idle(40);
        irq_in = 1'b1; ft1_in = 1'b1; ft2_in = 1'b0;
        bus_read(2'b00);
        chk("t5_status", 32'(bus_dout), 32'h00C0);
        bus_read(2'b10);
        chk("t5_port2", 32'(bus_dout), 0);
        irq_in = 1'b0; ft1_in = 1'b0;

        // Reset mid-stream discards the queue and clears the address latch.
        idle(40);
        base = seen.size();
        bus_write(2'b10, 8'h55);
        for (int i = 0; i < 8; i++) bus_write(2'b11, 8'(8'h60 + i));
        wait_pulses(base + 2, 200, "t6_two");
        bus_read(2'b00);
        chk("t6_pre_dout", 32'(bus_dout), 32'h0008);
        idle(5);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_busy",     32'(busy),        0);
        chk("t6_overflow", 32'(overflow),    0);
        chk("t6_dout",     32'(bus_dout),    0);
        chk("t6_reg_wr",   32'(opl3_reg_wr), 0);
        base2 = seen.size();
        idle(300);
        chk("t6_no_pulses", seen.size() - base2, 0);
        bus_write(2'b11, 8'h77);
        wait_pulses(base2 + 1, 100, "t6_after");
        if (seen.size() > base2) chk("t6_txn", 32'(seen[base2]), 32'(mk(1'b0, 8'h00, 8'h77)));

        // Random traffic: alternating sparse and dense phases, rare resets.
        for (int ph = 0; ph < 4; ph++) begin
            wprob = (ph % 2 == 1) ? 3 : 40;
            for (int k = 0; k < 1500; k++) begin
                bus_wr   = ($urandom_range(0, wprob - 1) == 0);
                bus_rd   = ($urandom_range(0, 7) == 0);
                bus_addr = 2'($urandom);
                bus_din  = 8'($urandom);
                irq_in   = 1'($urandom);
                ft1_in   = 1'($urandom);
                ft2_in   = 1'($urandom);
                reset_n  = ($urandom_range(0, 999) != 0);
                step();
            end
        end
        bus_wr = 1'b0; bus_rd = 1'b0; reset_n = 1'b1;
        wait_idle(DEPTH * GAP + 200, "final_idle", t_end);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
